// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, then shift one
// byte out on device clock edges and collect the device's acknowledge bit.
`timescale 1ns/1ps
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_error,
  output logic       tx_timeout,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StRequest, StSend, StWaitAck, StWaitIdle
  } state_e;

  localparam logic [CNT_WIDTH-1:0] InhibitLast = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RtsLast     = CNT_WIDTH'(RTS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne      = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [9:0]           shift_q, shift_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done_q, done_d;
  logic                 ack_err_q, ack_err_d;
  logic                 timeout_q, timeout_d;
  logic [1:0]           clk_sync_q, data_sync_q;
  logic                 clk_prev_q;

  logic clk_s, data_s, clk_fall, tmo_hit;

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_s;
  assign tmo_hit  = (cnt_q == TimeoutLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        // done_q keeps busy high for the completion cycle, so a start there is dropped
        if (tx_start && !tx_busy) begin
          shift_d   = {1'b1, ~^tx_data, tx_data};
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = StRequest;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRequest: begin
        if (cnt_q == RtsLast) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = StSend;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StSend, StWaitAck, StWaitIdle: begin
        if (tmo_hit) begin
          data_oe_d = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
          if (state_q == StSend) begin
            if (clk_fall) begin
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b1, shift_q[9:1]};
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd9) state_d = StWaitAck;
            end
          end else if (state_q == StWaitAck) begin
            if (clk_fall) begin
              ack_err_d = data_s;
              state_d   = StWaitIdle;
            end
          end else if (clk_s && data_s) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tx_busy      = (state_q != StIdle) | done_q;
  assign rx_inhibit   = tx_busy;
  assign tx_done      = done_q;
  assign tx_ack_error = ack_err_q;
  assign tx_timeout   = timeout_q;
  assign ps2_clk_oe   = (state_q == StInhibit) | (state_q == StRequest);
  assign ps2_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: behavioural PS/2 device plus a done-time scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_ack_error, tx_timeout, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Open-drain wiring: either side pulling low wins.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(20),
    .RTS_CYCLES    (4),
    .TIMEOUT_CYCLES(2000),
    .CNT_WIDTH     (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_ack_error(tx_ack_error),
    .tx_timeout  (tx_timeout),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] frame;
    bit         chk_frame;
    bit         ack_err;
    bit         tmo;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         inh_cnt, rts_cnt;
  logic [9:0] dev_frame;

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  task automatic push_exp(input logic [9:0] f, input bit chk, input bit ae, input bit tmo);
    exp_t e;
    e.frame = f; e.chk_frame = chk; e.ack_err = ae; e.tmo = tmo;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every tx_done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tx_done) begin
      done_cnt++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: tx_done=1 with no transfer outstanding");
      end else begin
        e = sb_q.pop_front();
        n_cmp++;
        if (tx_ack_error !== e.ack_err) begin
          n_err++;
          $display("FAIL ack_error_at_done: got %b want %b", tx_ack_error, e.ack_err);
        end
        n_cmp++;
        if (tx_timeout !== e.tmo) begin
          n_err++;
          $display("FAIL timeout_at_done: got %b want %b", tx_timeout, e.tmo);
        end
        n_cmp++;
        if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b001) begin
          n_err++;
          $display("FAIL lines_at_done: clk_oe,data_oe,busy got %b want 001",
                   {ps2_clk_oe, ps2_data_oe, tx_busy});
        end
        if (e.chk_frame) begin
          n_cmp++;
          if (dev_frame !== e.frame) begin
            n_err++;
            $display("FAIL frame: device sampled %b want %b", dev_frame, e.frame);
          end
        end
      end
    end
  end

  // Called on a negedge; returns on the first negedge after acceptance.
  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  // Device model: measures inhibit/RTS, clocks 40-clk bits, samples on rising edges.
  task automatic device_run(input bit ack, input int max_edges, input bit poke_busy);
    int n = 0;
    inh_cnt   = 0;
    rts_cnt   = 0;
    dev_frame = '0;
    while (!ps2_clk_oe && n < 10) begin n++; @(negedge clk); end
    while (ps2_clk_oe && !ps2_data_oe && inh_cnt < 200) begin inh_cnt++; @(negedge clk); end
    while (ps2_clk_oe && ps2_data_oe && rts_cnt < 200) begin rts_cnt++; @(negedge clk); end
    if (ps2_clk_oe || !ps2_data_oe) begin
      n_cmp++; n_err++;
      $display("FAIL rts_release: clk_oe=%b data_oe=%b want 0 1", ps2_clk_oe, ps2_data_oe);
      return;
    end
    repeat (20) @(negedge clk);
    for (int e = 1; e <= max_edges; e++) begin
      dev_clk = 1'b0;
      if (e == max_edges && max_edges < 11) begin
        repeat (5) @(negedge clk);
        return;
      end
      if (poke_busy && e == 3) begin
        repeat (4) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (15) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (e <= 10) dev_frame[e-1] = ps2_data_in;
      if (e == 10) begin
        repeat (10) @(negedge clk);
        dev_data = !ack;
        repeat (10) @(negedge clk);
      end else if (e == 11) begin
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
      end else begin
        repeat (20) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int c0, input int budget);
    int n = 0;
    while (done_cnt == c0 && n < budget) begin n++; @(negedge clk); end
    if (done_cnt == c0) begin
      n_cmp++; n_err++;
      $display("FAIL done_wait: no tx_done within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_busy, tx_done, tx_ack_error, tx_timeout, rx_inhibit, ps2_clk_oe, ps2_data_oe}
        !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {tx_busy, tx_done, tx_ack_error, tx_timeout, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy,clk_oe,data_oe got %b want 000",
               {tx_busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_nominal;
    int c0 = done_cnt;
    push_exp(frame_of(8'hED), 1'b1, 1'b0, 1'b0);
    start_tx(8'hED);
    n_cmp++;
    if ({tx_busy, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 4'b1110) begin
      n_err++;
      $display("FAIL accept_cycle: busy,rx_inh,clk_oe,data_oe got %b want 1110",
               {tx_busy, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    end
    device_run(1'b1, 11, 1'b0);
    n_cmp++;
    if (inh_cnt != 20) begin
      n_err++;
      $display("FAIL inhibit_len: got %0d cycles want 20", inh_cnt);
    end
    n_cmp++;
    if (rts_cnt != 4) begin
      n_err++;
      $display("FAIL rts_len: got %0d cycles want 4", rts_cnt);
    end
    wait_done(c0, 200);
  endtask

  task automatic test_parity;
    logic [7:0] d [2];
    logic       par [2];
    d[0] = 8'hF4; par[0] = 1'b0;
    d[1] = 8'h00; par[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int c0 = done_cnt;
      push_exp(frame_of(d[i]), 1'b1, 1'b0, 1'b0);
      start_tx(d[i]);
      device_run(1'b1, 11, 1'b0);
      wait_done(c0, 200);
      n_cmp++;
      if (dev_frame[8] !== par[i]) begin
        n_err++;
        $display("FAIL parity_%02h: got %b want %b", d[i], dev_frame[8], par[i]);
      end
    end
  endtask

  task automatic test_nack;
    int c0 = done_cnt;
    push_exp(frame_of(8'hA5), 1'b1, 1'b1, 1'b0);
    start_tx(8'hA5);
    device_run(1'b0, 11, 1'b0);
    wait_done(c0, 200);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (tx_ack_error !== 1'b1) begin
      n_err++;
      $display("FAIL nack_hold: tx_ack_error got %b want 1", tx_ack_error);
    end
    c0 = done_cnt;
    push_exp(frame_of(8'h3C), 1'b1, 1'b0, 1'b0);
    start_tx(8'h3C);
    n_cmp++;
    if (tx_ack_error !== 1'b0) begin
      n_err++;
      $display("FAIL nack_clear: tx_ack_error got %b want 0", tx_ack_error);
    end
    device_run(1'b1, 11, 1'b0);
    wait_done(c0, 200);
  endtask

  task automatic test_timeout;
    int n = 0;
    int cyc = 0;
    push_exp('0, 1'b0, 1'b0, 1'b1);
    start_tx(8'h5A);
    while (ps2_clk_oe && n < 200) begin n++; @(negedge clk); end
    while (!tx_done && cyc < 3000) begin cyc++; @(negedge clk); end
    n_cmp++;
    if (cyc != 2000) begin
      n_err++;
      $display("FAIL timeout_len: tx_done after %0d cycles want 2000", cyc);
    end
    @(negedge clk);
    n_cmp++;
    if ({tx_busy, tx_timeout, ps2_clk_oe, ps2_data_oe} !== 4'b0100) begin
      n_err++;
      $display("FAIL timeout_idle: busy,timeout,clk_oe,data_oe got %b want 0100",
               {tx_busy, tx_timeout, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_busy_start;
    int c0 = done_cnt;
    push_exp(frame_of(8'hC3), 1'b1, 1'b0, 1'b0);
    start_tx(8'hC3);
    device_run(1'b1, 11, 1'b1);
    wait_done(c0, 200);
    repeat (60) @(negedge clk);
    n_cmp++;
    if (done_cnt - c0 != 1) begin
      n_err++;
      $display("FAIL busy_start_dones: got %0d tx_done pulses want 1", done_cnt - c0);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int c1;
    push_exp(frame_of(8'h12), 1'b1, 1'b0, 1'b0);
    start_tx(8'h12);
    device_run(1'b1, 11, 1'b0);
    while (!tx_done && n < 200) begin n++; @(negedge clk); end
    if (!tx_done) begin
      n_cmp++; n_err++;
      $display("FAIL b2b_done: no tx_done within 200 cycles");
    end
    tx_data  = 8'h81;
    tx_start = 1'b1;
    push_exp(frame_of(8'h81), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_on_done: tx_busy got %b want 0", tx_busy);
    end
    @(negedge clk);
    tx_start = 1'b0;
    n_cmp++;
    if (tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_after_done: tx_busy got %b want 1", tx_busy);
    end
    c1 = done_cnt;
    device_run(1'b1, 11, 1'b0);
    wait_done(c1, 200);
  endtask

  task automatic test_reset_mid_send;
    int c0 = done_cnt;
    start_tx(8'hED);
    device_run(1'b1, 5, 1'b0);
    n_cmp++;
    if (ps2_data_oe !== 1'b1) begin
      n_err++;
      $display("FAIL bit4_drive: ps2_data_oe got %b want 1", ps2_data_oe);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset: clk_oe,data_oe,busy got %b want 000",
               {ps2_clk_oe, ps2_data_oe, tx_busy});
    end
    @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt != c0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d tx_done pulses want 0", done_cnt - c0);
    end
    c0 = done_cnt;
    push_exp(frame_of(8'hF4), 1'b1, 1'b0, 1'b0);
    start_tx(8'hF4);
    device_run(1'b1, 11, 1'b0);
    wait_done(c0, 200);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_parity();
    test_nack();
    test_timeout();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_send();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected transfers never completed want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
